// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the sequential signed divider: FSM encodings, default width
// and the add/sub select codes driven to the shared ALU.
package div_sequencer_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StAbsA = 3'd1,
        StAbsB = 3'd2,
        StIter = 3'd3,
        StSign = 3'd4,
        StDone = 3'd5
    } div_state_e;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider: synchronous clear, count enable and a flag that
// marks the last iteration.
module div_iter_counter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign terminal_o = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/div_sequencer.sv
// Signed restoring divider controller; every arithmetic step (abs values, iterations,
// sign fix) goes through one external add/sub unit, one operation per cycle.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output logic [WIDTH-1:0] alu_operandA,
    output logic [WIDTH-1:0] alu_operandB,
    output logic             alu_sub,
    input  logic [WIDTH-1:0] alu_result
);

    div_state_e state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] am_q, am_d, bm_q, bm_d;
    logic [WIDTH-1:0] p_q, p_d, d_q, d_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             neg_q, neg_d, exc_q, exc_d;
    logic             cnt_clear, cnt_en, cnt_terminal;
    logic [WIDTH-1:0] t;
    logic             no_borrow;

    div_iter_counter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_iter_counter (
        .clk_i     (clock),
        .reset_i   (reset),
        .clear_i   (cnt_clear),
        .enable_i  (cnt_en),
        .terminal_o(cnt_terminal)
    );

    // Shifted partial remainder and whether it covers the divisor (unsigned compare
    // reconstructed from the subtract result, since the ALU exposes no carry).
    assign t         = {p_q[WIDTH-2:0], d_q[WIDTH-1]};
    assign no_borrow = (t[WIDTH-1] & ~bm_q[WIDTH-1]) |
                       (~(t[WIDTH-1] ^ bm_q[WIDTH-1]) & ~alu_result[WIDTH-1]);

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        neg_d        = neg_q;
        am_d         = am_q;
        bm_d         = bm_q;
        p_d          = p_q;
        d_d          = d_q;
        result_d     = result_q;
        exc_d        = exc_q;
        alu_operandA = '0;
        alu_operandB = '0;
        alu_sub      = ALU_ADD;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;

        unique case (state_q)
            StIdle: ;
            StAbsA: begin
                alu_operandB = a_q;
                alu_sub      = ALU_SUB;
                am_d         = a_q[WIDTH-1] ? alu_result : a_q;
                if (b_q == '0) begin
                    result_d = '0;
                    exc_d    = 1'b1;
                    state_d  = StDone;
                end else begin
                    state_d  = StAbsB;
                end
            end
            StAbsB: begin
                alu_operandB = b_q;
                alu_sub      = ALU_SUB;
                bm_d         = b_q[WIDTH-1] ? alu_result : b_q;
                p_d          = '0;
                d_d          = am_q;
                state_d      = StIter;
            end
            StIter: begin
                alu_operandA = t;
                alu_operandB = bm_q;
                alu_sub      = ALU_SUB;
                p_d          = no_borrow ? alu_result : t;
                d_d          = {d_q[WIDTH-2:0], no_borrow};
                cnt_en       = 1'b1;
                state_d      = cnt_terminal ? StSign : StIter;
            end
            StSign: begin
                alu_operandB = d_q;
                alu_sub      = ALU_SUB;
                result_d     = neg_q ? alu_result : d_q;
                state_d      = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A start pulse wins in every state, aborting any operation in flight.
        if (ctrl_DIV) begin
            a_d       = data_operandA;
            b_d       = data_operandB;
            neg_d     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            exc_d     = 1'b0;
            cnt_clear = 1'b1;
            state_d   = StAbsA;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            am_q     <= '0;
            bm_q     <= '0;
            p_q      <= '0;
            d_q      <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            am_q     <= am_d;
            bm_q     <= bm_d;
            p_q      <= p_d;
            d_q      <= d_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == StDone);
    assign busy           = (state_q != StIdle);

endmodule
